// File: rtl/rv32i_types.sv
// ============================================================================
// Package : rv32i_types
// Shared widths and small helpers for the CPU-to-physical memory path.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int CPU_DATA_W  = 32;
    localparam int CPU_MASK_W  = 4;
    localparam int PMEM_DATA_W = 64;
    localparam int PMEM_MASK_W = 8;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // Places a 4-lane CPU byte enable into the upper or lower half of the 8-lane mask.
    function automatic logic [PMEM_MASK_W-1:0] lane_mask(input logic [CPU_MASK_W-1:0] be,
                                                         input logic lane);
        return lane ? {be, {CPU_MASK_W{1'b0}}} : {{CPU_MASK_W{1'b0}}, be};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_adaptor.sv
// ============================================================================
// Module  : mem_port_adaptor
// Bridges a 32-bit CPU memory port onto a 64-bit physical port with watchdog.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_port_adaptor
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            mem_address,
    input  logic [CPU_DATA_W-1:0]  mem_wdata,
    input  logic [CPU_MASK_W-1:0]  mem_byte_enable,
    output logic                   mem_resp,
    output logic [CPU_DATA_W-1:0]  mem_rdata,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [31:0]            pmem_address,
    output logic [PMEM_DATA_W-1:0] pmem_wdata,
    output logic [PMEM_MASK_W-1:0] pmem_wmask,
    input  logic                   pmem_resp,
    input  logic [PMEM_DATA_W-1:0] pmem_rdata,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Expiry fires on the last allowed stalled cycle so the strobe is held
    // for exactly TIMEOUT_CYCLES cycles.
    localparam logic [8:0] WD_LAST = 9'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [8:0]              watchdog;
    logic [31:3]             addr_q;
    logic [CPU_DATA_W-1:0]   wdata_q;
    logic [CPU_MASK_W-1:0]   be_q;
    logic                    lane_q;
    mem_op_t                 op_q;
    logic                    accept;
    logic                    pmem_done;
    logic                    wd_expire;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^mem_address[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pmem_done  = 1'b0;
        wd_expire  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        mem_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                pmem_read  = (op_q == OP_READ);
                pmem_write = (op_q == OP_WRITE);
                if (pmem_resp) begin
                    pmem_done  = 1'b1;
                    state_next = DONE;
                end else if (watchdog == WD_LAST) begin
                    wd_expire  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_resp   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            lane_q    <= 1'b0;
            op_q      <= OP_READ;
            watchdog  <= '0;
            mem_rdata <= '0;
            timeout   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= mem_address[31:3];
                wdata_q  <= mem_wdata;
                be_q     <= mem_byte_enable;
                lane_q   <= mem_address[2];
                op_q     <= mem_write ? OP_WRITE : OP_READ;
                watchdog <= '0;
            end else if ((state == ISSUE) && !pmem_resp) begin
                watchdog <= watchdog + 9'd1;
            end

            if (pmem_done && (op_q == OP_READ)) begin
                mem_rdata <= lane_q ? pmem_rdata[PMEM_DATA_W-1:CPU_DATA_W]
                                    : pmem_rdata[CPU_DATA_W-1:0];
            end else if (wd_expire) begin
                mem_rdata <= '0;
            end

            if (wd_expire) begin
                timeout <= 1'b1;
            end
        end
    end

    assign pmem_address = {addr_q, 3'b000};
    assign pmem_wdata   = {wdata_q, wdata_q};
    assign pmem_wmask   = lane_mask(be_q, lane_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_adaptor.sv
// ============================================================================
// Module  : tb_mem_port_adaptor
// Scoreboard bench for mem_port_adaptor with a scripted physical responder.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_port_adaptor;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [7:0]  pmem_wmask;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;
    logic        timeout;

    mem_port_adaptor #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_wmask      (pmem_wmask),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .timeout         (timeout)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        int          resp_cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec;
    int          n_err;
    logic [31:0] model_rdata;
    logic        model_tmo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
        check_value({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
        check_value({tag, "_pmem_read"}, 64'(pmem_read), 64'd0);
        check_value({tag, "_pmem_write"}, 64'(pmem_write), 64'd0);
        check_value({tag, "_pmem_address"}, 64'(pmem_address), 64'd0);
        check_value({tag, "_pmem_wdata"}, pmem_wdata, 64'd0);
        check_value({tag, "_pmem_wmask"}, 64'(pmem_wmask), 64'd0);
        check_value({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    // k is the ISSUE cycle carrying pmem_resp; k <= 0 withholds it.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [63:0] prd, input int k);
        exp_t        e;
        exp_t        got_e;
        logic        lane;
        logic [31:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        int          cyc;
        int          strobe_cycles;
        bit          got;

        lane      = addr[2];
        exp_addr  = {addr[31:3], 3'b000};
        exp_wdata = {wd, wd};
        exp_mask  = lane ? {be, 4'h0} : {4'h0, be};
        if (k <= 0) begin
            e.rdata      = 32'h0;
            e.tmo        = 1'b1;
            e.resp_cycle = TMO + 1;
        end else begin
            e.rdata      = wr ? model_rdata : (lane ? prd[63:32] : prd[31:0]);
            e.tmo        = model_tmo;
            e.resp_cycle = k + 1;
        end
        model_rdata = e.rdata;
        model_tmo   = e.tmo;
        exp_q.push_back(e);

        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        @(posedge clk);

        got           = 1'b0;
        cyc           = 1;
        strobe_cycles = 0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            mem_address     = $urandom;
            mem_wdata       = $urandom;
            mem_byte_enable = 4'($urandom);
            if (mem_resp) begin
                got_e = exp_q.pop_front();
                check_value("resp_cycle", 64'(cyc), 64'(got_e.resp_cycle));
                check_value("mem_rdata", 64'(mem_rdata), 64'(got_e.rdata));
                check_value("timeout_flag", 64'(timeout), 64'(got_e.tmo));
                check_value("done_strobe", 64'(pmem_read | pmem_write), 64'd0);
                got       = 1'b1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                pmem_resp = 1'b0;
            end else begin
                if (pmem_read | pmem_write) strobe_cycles++;
                check_value("pmem_read", 64'(pmem_read), 64'(rd & ~wr));
                check_value("pmem_write", 64'(pmem_write), 64'(wr));
                check_value("pmem_address", 64'(pmem_address), 64'(exp_addr));
                check_value("pmem_wdata", pmem_wdata, exp_wdata);
                check_value("pmem_wmask", 64'(pmem_wmask), 64'(exp_mask));
                pmem_resp  = (cyc == k);
                pmem_rdata = (cyc == k) ? prd : {$urandom, $urandom};
            end
            cyc++;
        end
        if (!got) begin
            check_value("resp_never_seen", 64'd0, 64'd1);
            void'(exp_q.pop_front());
            mem_read  = 1'b0;
            mem_write = 1'b0;
            pmem_resp = 1'b0;
        end
        check_value("strobe_cycles", 64'(strobe_cycles), 64'((k > 0) ? k : TMO));

        // The pulse must be single; a stray pmem_resp while idle must be ignored.
        @(negedge clk);
        check_value("resp_pulse_width", 64'(mem_resp), 64'd0);
        check_value("idle_strobe", 64'(pmem_read | pmem_write), 64'd0);
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_resp = 1'b0;
        check_value("stray_resp_no_pulse", 64'(mem_resp), 64'd0);
        check_value("stray_resp_rdata", 64'(mem_rdata), 64'(model_rdata));
    endtask

    task automatic reset_mid_issue();
        int resp_seen;
        @(negedge clk);
        mem_read        = 1'b1;
        mem_write       = 1'b0;
        mem_address     = 32'h0000_3ABC;
        mem_wdata       = 32'hDEAD_BEEF;
        mem_byte_enable = 4'hF;
        pmem_resp       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        mem_read = 1'b0;
        #1;
        check_outputs_zero("rst_mid_issue");
        @(negedge clk);
        rst         = 1'b0;
        model_rdata = 32'h0;
        model_tmo   = 1'b0;
        resp_seen   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_resp | pmem_read | pmem_write) resp_seen++;
        end
        check_value("rst_abandon", 64'(resp_seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_vec           = 0;
        n_err           = 0;
        model_rdata     = 32'h0;
        model_tmo       = 1'b0;
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;
        mem_byte_enable = 4'h0;
        pmem_resp       = 1'b0;
        pmem_rdata      = 64'h0;

        @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 64'hAAAA_BBBB_CCCC_DDDD, 3);
        run_txn(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 64'h0, 2);
        run_txn(1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'b1000, 64'h0, 1);
        run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 64'h1111_2222_3333_4444, 1);
        run_txn(1'b1, 1'b0, 32'h0000_4004, 32'h0, 4'hF, 64'h0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_5003, 32'h0, 4'hF, 64'h5555_6666_7777_8888, 4);
        run_txn(1'b0, 1'b1, 32'h0000_6006, 32'hA5A5_5A5A, 4'b0110, 64'h0, 8);

        for (int i = 0; i < 8; i++) begin
            logic        r_rd;
            logic        r_wr;
            logic [31:0] r_addr;
            r_rd   = 1'($urandom);
            r_wr   = 1'($urandom);
            if (!r_rd && !r_wr) r_rd = 1'b1;
            r_addr = $urandom;
            run_txn(r_rd, r_wr, r_addr, $urandom, 4'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 6)));
        end

        reset_mid_issue();
        run_txn(1'b1, 1'b0, 32'h0000_7004, 32'h0, 4'hF, 64'h9999_AAAA_BBBB_CCCC, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
